// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types and constants for the microwave BCD countdown timer
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } mwt_state_t;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_WRAP    = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with clear, parallel load and borrow out
module bcd_down_digit
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic [BCD_W-1:0] wrap_i,
    output logic [BCD_W-1:0] value_o,
    output logic             borrow_o
);

    logic [BCD_W-1:0] value_q, value_d;

    // Clear beats load beats decrement; decrementing from 0 wraps and borrows upward
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i) begin
            value_d = (value_q == '0) ? wrap_i : value_q - 1'b1;
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = dec_i && (value_q == '0);

endmodule

// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - MM:SS keypad-loaded BCD countdown timer; optional internal 1 Hz prescaler via MWT_PRESCALER_EN
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1hz,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clearn,
    input  logic       mag,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       zero
);

    mwt_state_t state_q, state_d;
    logic       done_q, done_d;
    logic       tick;
    logic       clr, load, dec;
    logic       borrow_so, borrow_st, borrow_mo, unused_borrow_mt;
    logic       last_second;

    assign clr         = !clearn;
    assign zero        = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    // In RUN the count is never zero, so a decrement lands on 00:00 only from 00:01
    assign last_second = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

`ifdef MWT_PRESCALER_EN
    localparam int               PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          unused_tick_1hz;

    // Counter is held at 0 outside RUN, so every entry into RUN starts a full second
    always_comb begin
        presc_d = '0;
        if (clearn && state_q == RUN) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick            = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign unused_tick_1hz = tick_1hz;
`else
    logic unused_clk_hz;

    assign tick          = tick_1hz;
    assign unused_clk_hz = CLK_HZ[0];
`endif

    // Next state, done flag and digit control; clear has priority over everything
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        load    = 1'b0;
        dec     = 1'b0;
        if (!clearn) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, SET: begin
                    if (mag) begin
                        if (zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (digit_valid && digit <= 4'd9) begin
                        load    = 1'b1;
                        state_d = ({min_ones, sec_tens, sec_ones, digit} != 16'h0000) ? SET : IDLE;
                    end
                end
                RUN: begin
                    if (tick) begin
                        dec = 1'b1;
                        if (last_second) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (!mag) begin
                            state_d = PAUSE;
                        end
                    end else if (!mag) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (mag) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and done-flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign timer_done = done_q;

    bcd_down_digit u_sec_ones (
        .clk(clk), .rstn(rstn), .clr_i(clr), .load_i(load), .load_val_i(digit),
        .dec_i(dec), .wrap_i(DIGIT_WRAP), .value_o(sec_ones), .borrow_o(borrow_so)
    );

    bcd_down_digit u_sec_tens (
        .clk(clk), .rstn(rstn), .clr_i(clr), .load_i(load), .load_val_i(sec_ones),
        .dec_i(borrow_so), .wrap_i(SEC_TENS_WRAP), .value_o(sec_tens), .borrow_o(borrow_st)
    );

    bcd_down_digit u_min_ones (
        .clk(clk), .rstn(rstn), .clr_i(clr), .load_i(load), .load_val_i(sec_tens),
        .dec_i(borrow_st), .wrap_i(DIGIT_WRAP), .value_o(min_ones), .borrow_o(borrow_mo)
    );

    bcd_down_digit u_min_tens (
        .clk(clk), .rstn(rstn), .clr_i(clr), .load_i(load), .load_val_i(min_ones),
        .dec_i(borrow_mo), .wrap_i(DIGIT_WRAP), .value_o(min_tens), .borrow_o(unused_borrow_mt)
    );

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - scoreboard bench for microwave_timer against a minutes/seconds reference model
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clearn = 1'b1;
    logic       mag = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, zero;

    microwave_timer #(.CLK_HZ(50_000_000)) dut (
        .clk(clk), .rstn(rstn), .tick_1hz(tick_1hz), .digit_valid(digit_valid),
        .digit(digit), .clearn(clearn), .mag(mag),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    // Reference model: mode 0 idle, 1 set, 2 run, 3 pause, 4 done; count kept as minutes and seconds
    int m_mode = 0;
    int m_min = 0;
    int m_sec = 0;

    function automatic logic [17:0] model_out();
        logic [17:0] r;
        r = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
             (m_mode == 4), (m_min == 0 && m_sec == 0)};
        return r;
    endfunction

    function automatic logic [17:0] dut_out();
        return {min_tens, min_ones, sec_tens, sec_ones, timer_done, zero};
    endfunction

    task automatic model_step(input int dv, input int d, input int cl, input int mg, input int tk);
        int v;
        if (cl == 0) begin
            m_min = 0; m_sec = 0; m_mode = 0;
        end else begin
            case (m_mode)
                0, 1: begin
                    if (mg != 0) begin
                        m_mode = (m_min == 0 && m_sec == 0) ? 4 : 2;
                    end else if (dv != 0 && d < 10) begin
                        v = ((m_min * 100 + m_sec) * 10 + d) % 10000;
                        m_min = v / 100;
                        m_sec = v % 100;
                        m_mode = (v != 0) ? 1 : 0;
                    end
                end
                2: begin
                    if (tk != 0) begin
                        if (m_sec > 0) m_sec = m_sec - 1;
                        else begin m_min = m_min - 1; m_sec = 59; end
                        if (m_min == 0 && m_sec == 0) m_mode = 4;
                        else if (mg == 0) m_mode = 3;
                    end else if (mg == 0) begin
                        m_mode = 3;
                    end
                end
                3: if (mg != 0) m_mode = 2;
                default: ;
            endcase
        end
    endtask

    // One clock of stimulus: drive at negedge, predict the post-edge outputs
    task automatic cyc(input int dv, input int d, input int cl, input int mg, input int tk);
        @(negedge clk);
        digit_valid = dv[0];
        digit       = d[3:0];
        clearn      = cl[0];
        mag         = mg[0];
        tick_1hz    = tk[0];
        model_step(dv, d, cl, mg, tk);
        exp_q.push_back(model_out());
    endtask

    task automatic key(input int d);
        cyc(1, d, 1, 0, 0);
    endtask

    task automatic check_now(input string name, input logic [17:0] expv);
        checks++;
        if (dut_out() !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, dut_out(), expv);
        end
    endtask

    // Checks the display right after the edge that consumed the last cyc()
    task automatic check_disp(input string name, input logic [15:0] d, input logic dn);
        @(posedge clk);
        #2;
        check_now(name, {d, dn, (d == 16'h0000)});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_now("async_reset", 18'h00001);
        #1;
        digit_valid = 1'b0; clearn = 1'b1; mag = 1'b0; tick_1hz = 1'b0;
        rstn = 1'b1;
        m_mode = 0; m_min = 0; m_sec = 0;
    endtask

    // Monitor: every edge that follows a stimulus cycle is compared against the scoreboard
    initial begin
        logic [17:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_out() !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got %h required %h", $time, dut_out(), e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mg;
        int dv;
        int cl;
        int tk;

        repeat (2) @(posedge clk);
        #2;
        check_now("reset_state", 18'h00001);
        #2;
        rstn = 1'b1;

        // Keys 1,3,0 then run three ticks
        key(1); key(3); key(0);
        check_disp("entry_0130", 16'h0130, 1'b0);
        cyc(0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0);
            cyc(0, 0, 1, 1, 1);
        end
        check_disp("run_0127", 16'h0127, 1'b0);

        // Reset mid-count, then a zero-count start proves the state came back to IDLE
        do_reset();
        cyc(0, 0, 1, 1, 0);
        check_disp("zero_start_after_reset", 16'h0000, 1'b1);
        cyc(0, 0, 0, 0, 0);

        // 00:01 expires on one tick and then holds
        key(1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        check_disp("expire_0000", 16'h0000, 1'b1);
        cyc(0, 0, 1, 1, 1); cyc(0, 0, 1, 1, 1);
        cyc(1, 5, 1, 1, 0); cyc(1, 5, 1, 0, 1);
        check_disp("done_holds", 16'h0000, 1'b1);
        cyc(0, 0, 0, 0, 0);
        check_disp("clear_done", 16'h0000, 1'b0);

        // 02:00 pause and resume
        key(2); key(0); key(0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        check_disp("borrow_0159", 16'h0159, 1'b0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
        check_disp("pause_holds", 16'h0159, 1'b0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        check_disp("resume_0158", 16'h0158, 1'b0);
        cyc(0, 0, 0, 0, 0);

        // Zero-time start, then clear beats a simultaneous digit
        cyc(0, 0, 1, 1, 0);
        check_disp("zero_time_start", 16'h0000, 1'b1);
        cyc(1, 7, 0, 1, 0);
        check_disp("clear_beats_digit", 16'h0000, 1'b0);
        cyc(0, 0, 1, 0, 0);

        // Overflow shift, invalid digit, keys during RUN
        for (int k = 1; k <= 5; k++) key(k);
        check_disp("shift_2345", 16'h2345, 1'b0);
        key(12);
        check_disp("digit12_ignored", 16'h2345, 1'b0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 9, 1, 1, 0); cyc(1, 3, 1, 1, 0);
        check_disp("keys_in_run", 16'h2345, 1'b0);
        cyc(0, 0, 0, 0, 0);

        // Tick and mag drop together: decrement then pause
        key(1); key(0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        check_disp("tick_with_mag_drop", 16'h0009, 1'b0);
        cyc(0, 0, 0, 0, 0);

        // Seconds-tens of 9 and a full borrow chain
        key(9); key(0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 1);
        check_disp("sec_tens_9", 16'h0089, 1'b0);
        cyc(0, 0, 0, 0, 0);
        key(1); key(0); key(0); key(0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);
        check_disp("chain_0959", 16'h0959, 1'b0);
        cyc(0, 0, 0, 0, 0);

        // Randomized traffic against the model
        mg = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) mg = 1 - mg;
            cl = ($urandom_range(63) == 0) ? 0 : 1;
            tk = ($urandom_range(2) == 0) ? 1 : 0;
            dv = (mg == 0 && $urandom_range(2) == 0) ? 1 : 0;
            cyc(dv, int'($urandom_range(15)), cl, mg, tk);
        end
        cyc(0, 0, 1, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never compared", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
